lsr_sample_loader: RTL and testbench
====================================

# lsr_sample_loader

Serial-to-parallel front end for the LSR regression core. Accepts signed 16-bit samples one per cycle over a valid/ready handshake, assembles a complete frame of `DATA_SIZE` samples into a registered array, then drives `data` and holds `start` high until the core reports completion. It sits between the sample source and the LSR core's `data`/`start`/`rst` inputs. It is the writing end of the LSR data interface.

## Interface
- `DATA_SIZE`, 7: samples per frame; must be ≥2.
- `WIDTH`, 16: sample width, signed two's complement.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset. Also drives the LSR core's `rst`.
- `in_valid`  in  1  source presents a sample.
- `in_data`  in  WIDTH (signed)  sample value.
- `in_last`  in  1  marks the final sample of a source frame.
- `in_ready`  out  1  loader accepts `in_data` this cycle.
- `lsr_done`  in  1  one-cycle pulse from the core: frame processed.
- `data`  out  array [0:DATA_SIZE-1] of WIDTH (signed)  frame to the core; index 0 is the first sample received.
- `start`  out  1  level; frame valid, core may run.
- `count`  out  $clog2(DATA_SIZE+1)  samples captured in the current frame.
- `frame_err`  out  1  one-cycle pulse: malformed frame discarded.

## Operation
- A transfer occurs when `in_valid && in_ready` on a rising edge.
- Two states:
  - **FILL**: `in_ready`=1, `start`=0.
  - **RUN**: `in_ready`=0, `start`=1, `data` frozen.
- **FILL** behaviour:
  - Each transfer writes `in_data` to `data[count]` and increments `count`.
  - A transfer that brings `count` to DATA_SIZE moves the block to RUN, provided `in_last`=1 on that transfer.
- **FILL** error cases (each gives a `frame_err` pulse, sets `count` to 0 and stays in FILL):
  - Short frame: `in_last`=1 on a transfer with `count` < DATA_SIZE-1.
  - Long frame: the DATA_SIZE-th transfer arrives with `in_last`=0.
  - `data` is not cleared in either case; stale entries are overwritten by the next frame.
- **RUN** behaviour:
  - `lsr_done`=1 causes the next state to be FILL and `count` to become 0.
  - `data` keeps the last frame until it is overwritten.
- `lsr_done` is ignored in FILL.
- `in_valid` is ignored in RUN, because `in_ready`=0 there.
- No arithmetic is performed. Samples are stored bit-exact; there is no sign extension or truncation.

## Timing
- Reset values: state FILL, `in_ready`=1, `start`=0, `count`=0, `frame_err`=0, every `data[i]`=0.
- `in_ready` is a combinational decode of state only. It has no combinational path from `in_valid`.
- `start` is registered. It rises in the first cycle after the edge that accepts the DATA_SIZE-th sample.
- Minimum frame-in to `start` latency: DATA_SIZE cycles from the first transfer, with `in_valid` held high.
- `start` falls and `in_ready` rises in the cycle after the edge sampling `lsr_done`=1.
- The first sample of the next frame is accepted one cycle after that edge at the earliest.
- Back-to-back frame period: DATA_SIZE + core latency + 1 cycles.
- `frame_err` is registered. It is high for exactly the one cycle after the offending transfer.
- `rst` in any state (including RUN with `start`=1) returns all outputs to their reset values at that edge. A partially captured frame is lost, and `lsr_done` on the same edge is ignored.
- Gaps in `in_valid` (bubbles) within a frame are allowed. `count` holds across them with no timeout.

## Test plan
- **Basic frame**: reset, then 7 back-to-back samples -3, 10, 0, 32767, -32768, 5, 1 with `in_last` on the 7th.
  - Required: `data` equals that sequence in order, `start`=1 one cycle later, `count`=7, `in_ready`=0.
- **Completion**: in RUN, pulse `lsr_done` once.
  - Required: `start`=0 and `in_ready`=1 next cycle, `count`=0, `data` unchanged.
- **Bubbles and backpressure**:
  - Deliver 7 samples with `in_valid` toggling 1,0,1,0…; `start` rises only after the 7th transfer.
  - Hold `in_valid`=1 through RUN; no sample is captured and `data` is unchanged.
- **Short and long frames**:
  - `in_last` on sample 4 gives a `frame_err` pulse, `count`=0, `start` stays 0.
  - 7 samples with `in_last`=0 gives a `frame_err` pulse, no `start`.
  - A following well-formed frame loads correctly.
- **Reset mid-RUN**: assert `rst` for 1 cycle while `start`=1.
  - Required: `start`=0, `count`=0, all `data`=0, `in_ready`=1 next cycle.
  - A `lsr_done` pulse on the same edge has no further effect.
- **Spurious done**: pulse `lsr_done` in FILL with `count`=3.
  - Required: `count` stays 3, and the frame completes normally after 4 more samples.

Source files
------------

// File: rtl/lsr_sample_loader.sv
// lsr_sample_loader: serial-to-parallel front end for the LSR regression core.
// Collects DATA_SIZE signed samples over a valid/ready handshake into a
// registered frame, then presents the frame on `data` and holds `start`
// until the core pulses `lsr_done`. Malformed frames (too short or too long,
// judged by `in_last`) are discarded with a one-cycle `frame_err` pulse.
module lsr_sample_loader #(
  parameter  int DATA_SIZE = 7,   // samples per frame, at least 2
  parameter  int WIDTH     = 16,  // sample width, two's complement
  localparam int CW        = $clog2(DATA_SIZE + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  input  logic                    lsr_done,
  output logic signed [WIDTH-1:0] data [0:DATA_SIZE-1],
  output logic                    start,
  output logic [CW-1:0]           count,
  output logic                    frame_err
);

  // FILL collects samples; RUN freezes the frame while the core works on it.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Index of the final slot in a frame, and the count reported while full.
  localparam logic [CW-1:0] LAST_IDX   = CW'(DATA_SIZE - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DATA_SIZE);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count_next;
  logic          err_next;
  logic          start_next;
  logic          wr_en;
  logic          xfer;

  // Ready depends on state alone, so there is no path from in_valid back to
  // in_ready and the source may legally wait on in_ready before asserting valid.
  assign in_ready = (state == FILL);
  assign xfer     = in_valid && in_ready;

  // Next-state, next-count and error decode for the frame assembler.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    count_next = count;
    err_next   = 1'b0;
    wr_en      = 1'b0;

    unique case (state)
      FILL: begin
        // lsr_done is deliberately ignored while filling.
        if (xfer) begin
          // Every accepted sample lands in the array, even one that turns out
          // to belong to a malformed frame; the next frame overwrites it.
          wr_en = 1'b1;
          if (count == LAST_IDX) begin
            if (in_last) begin
              state_next = RUN;
              count_next = FULL_COUNT;
            end else begin
              // Long frame: the final slot was filled without in_last.
              err_next   = 1'b1;
              count_next = '0;
            end
          end else if (in_last) begin
            // Short frame: in_last arrived before the final slot.
            err_next   = 1'b1;
            count_next = '0;
          end else begin
            count_next = count + CW'(1);
          end
        end
      end

      RUN: begin
        if (lsr_done) begin
          state_next = FILL;
          count_next = '0;
        end
      end

      default: begin
        state_next = FILL;
        count_next = '0;
      end
    endcase

    start_next = (state_next == RUN);
  end

  // State, count, start and error registers with synchronous reset.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      count     <= '0;
      start     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      start     <= start_next;
      frame_err <= err_next;
    end
  end

  // Sample array: written at the current count on each accepted sample.
  // NOTE: this array is reset on purpose; the core's input must read as all
  // zeros after reset, so it is built from resettable flops rather than a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DATA_SIZE; i++) begin
        data[i] <= '0;
      end
    end else if (wr_en) begin
      data[count] <= in_data;
    end
  end

endmodule

// File: tb/tb_lsr_sample_loader.sv
// Self-checking bench for lsr_sample_loader: a table of vectors for the basic
// frame and completion, hand-written corner sequences, then randomized
// traffic compared cycle by cycle against a frame-level reference model.
module tb_lsr_sample_loader;

  localparam int DS = 7;
  localparam int W  = 16;
  localparam int CW = $clog2(DS + 1);

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic signed [W-1:0] in_data;
  logic                in_last;
  logic                in_ready;
  logic                lsr_done;
  logic signed [W-1:0] data [0:DS-1];
  logic                start;
  logic [CW-1:0]       count;
  logic                frame_err;

  int checks = 0;
  int errors = 0;

  // Reference model state: frame-level view of what the loader should hold.
  bit                  m_run;
  int                  m_cnt;
  logic signed [W-1:0] m_data [0:DS-1];
  bit                  m_err;

  lsr_sample_loader #(.DATA_SIZE(DS), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .lsr_done  (lsr_done),
    .data      (data),
    .start     (start),
    .count     (count),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the model's rules for one rising edge with the given inputs.
  task automatic model_edge(input bit r, input bit v, input logic signed [W-1:0] d,
                            input bit l, input bit dn);
    m_err = 1'b0;
    if (r) begin
      m_run = 1'b0;
      m_cnt = 0;
      for (int i = 0; i < DS; i++) m_data[i] = '0;
    end else if (m_run) begin
      if (dn) begin
        m_run = 1'b0;
        m_cnt = 0;
      end
    end else if (v) begin
      m_data[m_cnt] = d;
      m_cnt++;
      if (m_cnt == DS) begin
        if (l) m_run = 1'b1;
        else begin
          m_err = 1'b1;
          m_cnt = 0;
        end
      end else if (l) begin
        m_err = 1'b1;
        m_cnt = 0;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(!m_run));
    check({tag, ".start"}, 32'(start), 32'(m_run));
    check({tag, ".count"}, 32'(count), 32'(m_cnt));
    check({tag, ".frame_err"}, 32'(frame_err), 32'(m_err));
    for (int i = 0; i < DS; i++)
      check($sformatf("%s.data[%0d]", tag, i), 32'(data[i]), 32'(m_data[i]));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare against the model.
  task automatic step(input string tag, input bit r, input bit v,
                      input logic signed [W-1:0] d, input bit l, input bit dn);
    rst      = r;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    lsr_done = dn;
    model_edge(r, v, d, l, dn);
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Load a well-formed frame of samples base, base+1, ... back to back.
  task automatic load_frame(input string tag, input int base);
    for (int i = 0; i < DS; i++)
      step(tag, 1'b0, 1'b1, W'(base + i), (i == DS - 1), 1'b0);
  endtask

  typedef struct {
    bit                  v;
    logic signed [W-1:0] d;
    bit                  l;
    bit                  dn;
    bit                  e_ready;
    bit                  e_start;
    int                  e_count;
    bit                  e_err;
  } vec_t;

  vec_t                vecs [0:DS];
  logic signed [W-1:0] basic [0:DS-1];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; lsr_done = 1'b0;

    // Reset state.
    step("reset", 1'b1, 1'b0, '0, 1'b0, 1'b0);
    step("reset", 1'b1, 1'b1, 16'sd99, 1'b1, 1'b1);
    check("reset.count_zero", 32'(count), 32'd0);
    check("reset.start_low", 32'(start), 32'd0);
    check("reset.ready_high", 32'(in_ready), 32'd1);

    // Basic frame and completion from a table of expected outputs.
    basic[0] = -16'sd3;  basic[1] = 16'sd10; basic[2] = 16'sd0; basic[3] = 16'sd32767;
    basic[4] = -16'sd32768; basic[5] = 16'sd5; basic[6] = 16'sd1;
    for (int i = 0; i < DS; i++)
      vecs[i] = '{v: 1'b1, d: basic[i], l: (i == DS - 1), dn: 1'b0,
                  e_ready: (i != DS - 1), e_start: (i == DS - 1), e_count: i + 1, e_err: 1'b0};
    vecs[DS] = '{v: 1'b0, d: '0, l: 1'b0, dn: 1'b1,
                 e_ready: 1'b1, e_start: 1'b0, e_count: 0, e_err: 1'b0};
    for (int i = 0; i <= DS; i++) begin
      step($sformatf("vec%0d", i), 1'b0, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].dn);
      check($sformatf("vec%0d.ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d.start", i), 32'(start), 32'(vecs[i].e_start));
      check($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("vec%0d.err", i), 32'(frame_err), 32'(vecs[i].e_err));
      if (i >= DS - 1)
        for (int k = 0; k < DS; k++)
          check($sformatf("vec%0d.data%0d", i, k), 32'(data[k]), 32'(basic[k]));
    end

    // Bubbles: valid toggles 1,0,1,0...; start only after the 7th transfer.
    for (int i = 0; i < DS; i++) begin
      step("bubble", 1'b0, 1'b1, W'(100 + i), (i == DS - 1), 1'b0);
      if (i != DS - 1) begin
        check("bubble.no_start", 32'(start), 32'd0);
        step("bubble_gap", 1'b0, 1'b0, 16'sd777, 1'b1, 1'b0);
        check("bubble.count_hold", 32'(count), 32'(i + 1));
      end
    end
    check("bubble.start", 32'(start), 32'd1);

    // Backpressure: valid held high in RUN must not disturb the frame.
    for (int i = 0; i < 3; i++)
      step("backpressure", 1'b0, 1'b1, W'(-500 - i), 1'b1, 1'b0);
    check("backpressure.data0", 32'(data[0]), 32'(16'sd100));
    check("backpressure.data6", 32'(data[DS-1]), 32'(16'sd106));
    step("bp_done", 1'b0, 1'b1, 16'sd1234, 1'b0, 1'b1);
    check("bp_done.count", 32'(count), 32'd0);

    // Short frame: in_last on sample 4.
    for (int i = 0; i < 4; i++)
      step("short", 1'b0, 1'b1, W'(200 + i), (i == 3), 1'b0);
    check("short.err", 32'(frame_err), 32'd1);
    check("short.count", 32'(count), 32'd0);
    check("short.start", 32'(start), 32'd0);
    idle("short_after");
    check("short.err_one_cycle", 32'(frame_err), 32'd0);

    // Long frame: seven samples with in_last low.
    for (int i = 0; i < DS; i++)
      step("long", 1'b0, 1'b1, W'(300 + i), 1'b0, 1'b0);
    check("long.err", 32'(frame_err), 32'd1);
    check("long.no_start", 32'(start), 32'd0);
    idle("long_after");
    check("long.err_one_cycle", 32'(frame_err), 32'd0);

    // A well-formed frame after the errors loads correctly.
    load_frame("recover", 400);
    check("recover.start", 32'(start), 32'd1);
    check("recover.data3", 32'(data[3]), 32'(16'sd403));

    // Reset mid-RUN, with lsr_done on the same edge.
    step("rst_run", 1'b1, 1'b0, '0, 1'b0, 1'b1);
    check("rst_run.start", 32'(start), 32'd0);
    check("rst_run.ready", 32'(in_ready), 32'd1);
    check("rst_run.data0", 32'(data[0]), 32'd0);
    idle("rst_run_after");
    check("rst_run_after.count", 32'(count), 32'd0);

    // Spurious done in FILL with count=3.
    for (int i = 0; i < 3; i++)
      step("spurious", 1'b0, 1'b1, W'(-600 + i), 1'b0, 1'b0);
    step("spurious_done", 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("spurious.count_hold", 32'(count), 32'd3);
    for (int i = 3; i < DS; i++)
      step("spurious_fill", 1'b0, 1'b1, W'(-600 + i), (i == DS - 1), 1'b0);
    check("spurious.start", 32'(start), 32'd1);
    check("spurious.data0", 32'(data[0]), 32'(-16'sd600));
    step("spurious_end", 1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      bit                  r, v, l, dn;
      logic signed [W-1:0] d;
      r  = ($urandom_range(0, 199) == 0);
      v  = ($urandom_range(0, 9) < 7);
      d  = W'($urandom);
      if (m_cnt == DS - 1) l = ($urandom_range(0, 9) != 0);
      else                 l = ($urandom_range(0, 29) == 0);
      dn = m_run ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0);
      step("random", r, v, d, l, dn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
